// File: rtl/div_pkg.sv
// Shared types for the ROM-fed operand divider: FSM state encoding and
// counter-width helpers evaluated at elaboration time.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_A,
        WAIT_A,
        FETCH_B,
        WAIT_B,
        DIVIDE,
        DONE,
        SIGNFIX
    } divState_t;

    // Iteration counter must hold 0..dataW.
    function automatic int iterCntWidth(input int dataW);
        return $clog2(dataW + 1);
    endfunction

    // Wait counter only needs 0..romLat-1, but never narrower than one bit.
    function automatic int latCntWidth(input int romLat);
        return (romLat < 2) ? 1 : $clog2(romLat);
    endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One combinational restoring-division iteration: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, keep if non-negative.
module div_restoring_step #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W:0]   partRem,
    input  logic              nextBit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W:0]   remNext,
    output logic              qBit
);

    logic [DATA_W+1:0] shifted;
    logic [DATA_W+1:0] diff;

    always_comb begin
        shifted = {partRem, nextBit};
        diff    = shifted - {2'b00, divisor};
        // A clear top bit means the trial subtraction did not borrow.
        qBit    = ~diff[DATA_W+1];
        remNext = qBit ? diff[DATA_W:0] : shifted[DATA_W:0];
    end

endmodule

// File: rtl/rom_operand_divider.sv
// Fetches dividend/divisor from a synchronous ROM and divides them with a
// DATA_W-cycle restoring engine. Define DIV_SIGNED_EN for two's-complement operands.
module rom_operand_divider
    import div_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 9,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addressA,
    input  logic [ADDR_W-1:0] addressB,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              busy,
    output logic              finished,
    output logic              div_by_zero
);

    localparam int CNT_W = iterCntWidth(DATA_W);
    localparam int LAT_W = latCntWidth(ROM_LAT);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);
    localparam logic [LAT_W-1:0] LAST_WAIT = LAT_W'(ROM_LAT - 1);

    divState_t         stateReg, stateNext;
    logic [ADDR_W-1:0] addrBReg;
    logic [ADDR_W-1:0] romAddrReg;
    logic [LAT_W-1:0]  latCntReg;
    logic [CNT_W-1:0]  iterCntReg;
    logic [DATA_W-1:0] dividendReg;
    logic [DATA_W-1:0] divisorReg;
    logic [DATA_W-1:0] workReg;
    logic [DATA_W:0]   remReg;
    logic [DATA_W-1:0] quotientReg;
    logic [DATA_W-1:0] remainderReg;
    logic              divByZeroReg;

    logic              lastWait;
    logic              lastIter;
    logic              divisorZero;
    logic [DATA_W-1:0] dividendMag;
    logic [DATA_W-1:0] divisorMag;
    logic [DATA_W:0]   remStep;
    logic              qBit;

    assign lastWait    = (latCntReg == LAST_WAIT);
    assign lastIter    = (iterCntReg == LAST_ITER);
    assign divisorZero = (rom_data == '0);

`ifdef DIV_SIGNED_EN
    logic dividendNeg;
    logic divisorNeg;
    logic negQuoReg;
    logic negRemReg;

    // MIN has no positive counterpart, but its magnitude fits as unsigned.
    assign dividendNeg = dividendReg[DATA_W-1];
    assign divisorNeg  = rom_data[DATA_W-1];
    assign dividendMag = dividendNeg ? -dividendReg : dividendReg;
    assign divisorMag  = divisorNeg ? -rom_data : rom_data;
`else
    assign dividendMag = dividendReg;
    assign divisorMag  = rom_data;
`endif

    div_restoring_step #(
        .DATA_W (DATA_W)
    ) stepInst (
        .partRem (remReg),
        .nextBit (workReg[DATA_W-1]),
        .divisor (divisorReg),
        .remNext (remStep),
        .qBit    (qBit)
    );

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (start) stateNext = FETCH_A;
            FETCH_A: stateNext = WAIT_A;
            WAIT_A:  if (lastWait) stateNext = FETCH_B;
            FETCH_B: stateNext = WAIT_B;
            WAIT_B:  if (lastWait) stateNext = divisorZero ? DONE : DIVIDE;
            DIVIDE: begin
                if (lastIter) begin
`ifdef DIV_SIGNED_EN
                    stateNext = SIGNFIX;
`else
                    stateNext = DONE;
`endif
                end
            end
            SIGNFIX: stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg     <= IDLE;
            addrBReg     <= '0;
            romAddrReg   <= '0;
            latCntReg    <= '0;
            iterCntReg   <= '0;
            dividendReg  <= '0;
            divisorReg   <= '0;
            workReg      <= '0;
            remReg       <= '0;
            quotientReg  <= '0;
            remainderReg <= '0;
            divByZeroReg <= 1'b0;
`ifdef DIV_SIGNED_EN
            negQuoReg    <= 1'b0;
            negRemReg    <= 1'b0;
`endif
        end else begin
            stateReg <= stateNext;
            case (stateReg)
                IDLE: begin
                    if (start) begin
                        romAddrReg   <= addressA;
                        addrBReg     <= addressB;
                        divByZeroReg <= 1'b0;
                    end
                end
                FETCH_A, FETCH_B: latCntReg <= '0;
                WAIT_A: begin
                    latCntReg <= latCntReg + LAT_W'(1);
                    if (lastWait) begin
                        dividendReg <= rom_data;
                        romAddrReg  <= addrBReg;
                    end
                end
                WAIT_B: begin
                    latCntReg <= latCntReg + LAT_W'(1);
                    if (lastWait) begin
                        if (divisorZero) begin
                            quotientReg  <= '1;
                            remainderReg <= dividendReg;
                            divByZeroReg <= 1'b1;
                        end else begin
                            divisorReg <= divisorMag;
                            workReg    <= dividendMag;
                            remReg     <= '0;
                            iterCntReg <= '0;
`ifdef DIV_SIGNED_EN
                            negQuoReg  <= dividendNeg ^ divisorNeg;
                            negRemReg  <= dividendNeg;
`endif
                        end
                    end
                end
                DIVIDE: begin
                    // workReg shifts dividend bits out the top and quotient bits in the bottom.
                    workReg    <= {workReg[DATA_W-2:0], qBit};
                    remReg     <= remStep;
                    iterCntReg <= iterCntReg + CNT_W'(1);
`ifndef DIV_SIGNED_EN
                    if (lastIter) begin
                        quotientReg  <= {workReg[DATA_W-2:0], qBit};
                        remainderReg <= remStep[DATA_W-1:0];
                    end
`endif
                end
`ifdef DIV_SIGNED_EN
                SIGNFIX: begin
                    quotientReg  <= negQuoReg ? -workReg : workReg;
                    remainderReg <= negRemReg ? -remReg[DATA_W-1:0] : remReg[DATA_W-1:0];
                end
`endif
                default: ;
            endcase
        end
    end

    assign rom_en      = (stateReg == FETCH_A) || (stateReg == FETCH_B);
    assign rom_addr    = romAddrReg;
    assign quotient    = quotientReg;
    assign remainder   = remainderReg;
    assign busy        = (stateReg != IDLE);
    assign finished    = (stateReg == DONE);
    assign div_by_zero = divByZeroReg;

endmodule

// File: tb/tb_rom_operand_divider.sv
// Directed bench for rom_operand_divider: ROM model with configurable latency,
// hand-computed quotient/remainder/latency vectors, mid-operation reset.
module tb_rom_operand_divider;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 9;
    localparam int ROM_LAT = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] addressA = '0;
    logic [ADDR_W-1:0] addressB = '0;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    logic              busy;
    logic              finished;
    logic              div_by_zero;

    int testCount = 0;
    int failCount = 0;

    logic [DATA_W-1:0] romMem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] romPipe [0:ROM_LAT-1];

    always #5 clk = ~clk;

    rom_operand_divider #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ROM_LAT (ROM_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .addressA    (addressA),
        .addressB    (addressB),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .finished    (finished),
        .div_by_zero (div_by_zero)
    );

    // Synchronous ROM: read launched by rom_en, data appears ROM_LAT edges later and holds.
    always @(posedge clk) begin
        if (rom_en) romPipe[0] <= romMem[rom_addr];
        for (int i = 1; i < ROM_LAT; i++) romPipe[i] <= romPipe[i-1];
    end
    assign rom_data = romPipe[ROM_LAT-1];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Returns at the falling edge of cycle 1 (first cycle after the start edge).
    task automatic startOp(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        @(negedge clk);
        addressA = a;
        addressB = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic doOp(input string name, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                        input int pulse1, input int pulse2, input int expLat,
                        input logic [DATA_W-1:0] expQ, input logic [DATA_W-1:0] expR, input logic expDbz,
                        input logic [DATA_W-1:0] expHeldQ);
        int   finCycle;
        int   finCount;
        int   busyDrops;
        logic busyAfter;
        finCycle  = -1;
        finCount  = 0;
        busyDrops = 0;
        busyAfter = 1'b1;
        startOp(a, b);
        checkVal({name, ".heldQ"}, 32'(quotient), 32'(expHeldQ));
        checkVal({name, ".dbzClr"}, 32'(div_by_zero), 32'd0);
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            start = (c == pulse1) || (c == pulse2);
            if (finished) begin
                finCount++;
                if (finCycle < 0) finCycle = c;
            end
            if (finCycle < 0 && !busy) busyDrops++;
            if (finCycle > 0 && c == finCycle + 1) begin
                busyAfter = busy;
                break;
            end
        end
        start = 1'b0;
        $display("[TB] op %s: q=%0d r=%0d dbz=%0d finished@%0d", name, quotient, remainder, div_by_zero, finCycle);
        checkVal({name, ".lat"}, 32'(finCycle), 32'(expLat));
        checkVal({name, ".quo"}, 32'(quotient), 32'(expQ));
        checkVal({name, ".rem"}, 32'(remainder), 32'(expR));
        checkVal({name, ".dbz"}, 32'(div_by_zero), 32'(expDbz));
        checkVal({name, ".finCnt"}, 32'(finCount), 32'd1);
        checkVal({name, ".busyDrop"}, 32'(busyDrops), 32'd0);
        checkVal({name, ".busyAfter"}, 32'(busyAfter), 32'd0);
    endtask

    initial begin
        int finSeen;
        for (int i = 0; i < (1 << ADDR_W); i++) romMem[i] = '0;
        for (int i = 0; i < ROM_LAT; i++) romPipe[i] = '0;
        romMem[10]  = 8'd200; romMem[20]  = 8'd7;
        romMem[30]  = 8'd5;   romMem[40]  = 8'd0;
        romMem[50]  = 8'd3;   romMem[60]  = 8'd9;
        romMem[70]  = 8'd255; romMem[80]  = 8'd1;
        romMem[90]  = 8'd100; romMem[100] = 8'd3;
        romMem[110] = 8'hF9;  romMem[120] = 8'd2;

        repeat (3) @(negedge clk);
        checkVal("rst.busy", 32'(busy), 32'd0);
        checkVal("rst.finished", 32'(finished), 32'd0);
        checkVal("rst.romEn", 32'(rom_en), 32'd0);
        checkVal("rst.romAddr", 32'(rom_addr), 32'd0);
        checkVal("rst.quo", 32'(quotient), 32'd0);
        checkVal("rst.rem", 32'(remainder), 32'd0);
        checkVal("rst.dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;

`ifdef DIV_SIGNED_EN
        doOp("sgn",   110, 120, 0, 0, 14, 8'hFD, 8'hFF, 1'b0, 8'd0);
        doOp("dbz",   30,  40,  0, 0, 5,  8'hFF, 8'd5,  1'b1, 8'hFD);
`else
        doOp("200/7", 10,  20,  0, 0, 13, 8'd28,  8'd4, 1'b0, 8'd0);
        doOp("5/0",   30,  40,  0, 0, 5,  8'hFF,  8'd5, 1'b1, 8'd28);
        doOp("3/9",   50,  60,  0, 0, 13, 8'd0,   8'd3, 1'b0, 8'hFF);
        doOp("255/1", 70,  80,  0, 0, 13, 8'd255, 8'd0, 1'b0, 8'd0);
        doOp("busyStart", 90, 100, 3, 8, 13, 8'd33, 8'd1, 1'b0, 8'd255);

        // Reset in the middle of DIVIDE (cycle 7).
        startOp(10, 20);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] op midReset: busy=%0d q=%0d r=%0d", busy, quotient, remainder);
        checkVal("midRst.busy", 32'(busy), 32'd0);
        checkVal("midRst.finished", 32'(finished), 32'd0);
        checkVal("midRst.romEn", 32'(rom_en), 32'd0);
        checkVal("midRst.romAddr", 32'(rom_addr), 32'd0);
        checkVal("midRst.quo", 32'(quotient), 32'd0);
        checkVal("midRst.rem", 32'(remainder), 32'd0);
        finSeen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (finished || busy) finSeen++;
        end
        checkVal("midRst.noFinish", 32'(finSeen), 32'd0);
        doOp("afterRst", 10, 20, 0, 0, 13, 8'd28, 8'd4, 1'b0, 8'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
